shift_right_seq: RTL and testbench
==================================

Name: shift_right_seq

Overview:
- Sequential right shifter: the inverse of the team's widening left shifter.
- Takes a DOW-wide operand and a shift count, shifts right one bit per clock, and returns the DIW-wide result.
- Also returns a sticky bit (OR of all bits shifted out) and an overflow flag (result does not fit DIW bits).
- Sits behind valid/ready handshakes on both sides; used where a prior widening shift must be undone, e.g. denormalization and rounding paths.

Parameters:
- DIW, 8, output data width.
- SW, $clog2(DIW), shift count width.
- DOW, 2*DIW-1, input data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- a  in  DOW  operand to shift right.
- n  in  SW  shift count, 0..2^SW-1 (always <= DOW-1, so every value is legal).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- y  out  DIW  low DIW bits of (a >> n).
- sticky  out  1  OR of all bits shifted out.
- ovf  out  1  OR of bits DOW-1..DIW of (a >> n).

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst); polarity and synchronicity are fixed.
- Reset values: state=IDLE, out_valid=0, y=0, sticky=0, ovf=0, internal shift register=0, count=0. in_ready=1 once reset deasserts.
- State machine has three states.
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept occurs on a rising edge with in_valid && in_ready.
  - Loads shift register <= a, count <= n, sticky <= 0.
  - Next state is SHIFT if n!=0, else DONE.
- SHIFT, each edge: sticky <= sticky | sr[0]; sr <= sr >> 1 (zero fill); count <= count-1. When count==1, next state is DONE.
- Latency: out_valid first goes high after the (n+1)-th rising edge counting the accepting edge. For n=0 that is the cycle after accept. No bubble between the final shift and DONE.
- Outputs are registered and driven from DONE-state registers:
  - y = sr[DIW-1:0]
  - ovf = |sr[DOW-1:DIW]
  - sticky as accumulated
- y, sticky and ovf are stable while out_valid && !out_ready. a and n are not sampled after accept.
- DONE with out_ready=1:
  - With in_valid=1: result handshake and new accept on the same edge; next state follows the new n. Gives back-to-back operation with no IDLE bubble.
  - With in_valid=0: next state IDLE, out_valid falls.
- in_ready is combinational from state and out_ready only. No combinational path from in_valid to in_ready.
- rst asserted in any state: immediate return to reset values. An in-flight operation is dropped with no partial result.
- Throughput: one result per n+1 cycles.

Decomposition:
- Shared package (shift_pkg) holds:
  - the state enum typedef (IDLE, SHIFT, DONE)
  - a width-function helper for DOW (2*DIW-1), shared with the left shifter.
- No sub-module. Counter and shift register are a single always_ff.
- The state register and next-state logic sit in one always_ff/always_comb pair.

Test Plan:
- DIW=8, DOW=15 for all scenarios.
- a=15'h0B40, n=6, out_ready=1 -> out_valid after 7th edge incl. accept; y=8'h2D, sticky=0, ovf=0.
- a=15'h0B41, n=6 -> y=8'h2D, sticky=1, ovf=0. Then a=15'h7FFF, n=7 -> y=8'hFF, sticky=1, ovf=0.
- n=0: a=15'h00FF -> y=8'hFF, ovf=0, out_valid the cycle after accept. a=15'h01FF, n=0 -> y=8'hFF, ovf=1, sticky=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> y, sticky, ovf and out_valid stay constant; in_ready=0. Release -> one handshake, back to IDLE.
- Back-to-back: in_valid held high, out_ready=1, n=2 each op -> new accept on every result edge; a result every 3 cycles; no IDLE cycle.
- Reset mid-op: n=7, assert rst 3 cycles after accept -> out_valid=0 and y=0 asynchronously. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the sequential left/right shifter family:
// the handshake FSM state encoding and the operand-width helper.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A widening shift of a DIW-bit value by up to DIW-1 places needs 2*DIW-1 bits.
  function automatic int dow_width(input int diw);
    return 2 * diw - 1;
  endfunction

endpackage

// File: rtl/shift_right_seq.sv
// Sequential right shifter: one bit per clock, returning the low DIW bits of
// (a >> n) together with the sticky (bits shifted out) and overflow flags.
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int DIW = 8,
  parameter int SW  = $clog2(DIW),
  parameter int DOW = dow_width(DIW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DOW-1:0] a,
  input  logic [SW-1:0]  n,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DIW-1:0] y,
  output logic           sticky,
  output logic           ovf
);

  state_t         state;
  state_t         state_next;
  logic [DOW-1:0] sr;
  logic [SW-1:0]  count;
  logic           accept;

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) state_next = (n != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (count == SW'(1)) state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_next = (n != '0) ? SHIFT : DONE;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath. y and ovf are re-registered alongside each sr update so that in
  // DONE they already reflect the final sr and stay put under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      count  <= '0;
      sticky <= 1'b0;
      y      <= '0;
      ovf    <= 1'b0;
    end else if (accept) begin
      sr     <= a;
      count  <= n;
      sticky <= 1'b0;
      y      <= a[DIW-1:0];
      ovf    <= |a[DOW-1:DIW];
    end else if (state == SHIFT) begin
      sr     <= sr >> 1;
      count  <= count - SW'(1);
      sticky <= sticky | sr[0];
      y      <= sr[DIW:1];
      ovf    <= |sr[DOW-1:DIW+1];
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed cases, backpressure,
// back-to-back, reset mid-operation and random operands against a model.
module tb_shift_right_seq;

  localparam int DIW = 8;
  localparam int SW  = 3;
  localparam int DOW = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DOW-1:0] a;
  logic [SW-1:0]  n;
  logic           out_valid;
  logic           out_ready;
  logic [DIW-1:0] y;
  logic           sticky;
  logic           ovf;

  int checks   = 0;
  int failures = 0;

  shift_right_seq #(.DIW(DIW), .SW(SW), .DOW(DOW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .n         (n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .sticky    (sticky),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the full operand value.
  function automatic logic [9:0] model(input logic [DOW-1:0] av, input logic [SW-1:0] nv);
    int unsigned full, shifted, lost;
    full    = av;
    shifted = full >> nv;
    lost    = full & ((32'd1 << nv) - 1);
    return {((shifted >> DIW) != 0), (lost != 0), shifted[7:0]};
  endfunction

  task automatic check_result(input string tag, input logic [DOW-1:0] av, input logic [SW-1:0] nv);
    logic [9:0] e;
    e = model(av, nv);
    check({tag, ".y"},      32'(y),      32'(e[7:0]));
    check({tag, ".sticky"}, 32'(sticky), 32'(e[8]));
    check({tag, ".ovf"},    32'(ovf),    32'(e[9]));
  endtask

  // One complete operation with out_ready=1; checks latency and results.
  task automatic run_op(input string tag, input logic [DOW-1:0] av, input logic [SW-1:0] nv);
    int edges;
    @(negedge clk);
    in_valid = 1'b1; a = av; n = nv; out_ready = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0; a = DOW'($urandom); n = SW'($urandom);
    while (!out_valid && edges < 20) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    check({tag, ".latency"}, 32'(edges), 32'(nv) + 32'd1);
    check_result(tag, av, nv);
    @(posedge clk); @(negedge clk);
    check({tag, ".release"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [DOW-1:0] q[5];
    logic [DOW-1:0] ra;
    logic [SW-1:0]  rn;
    logic [DIW-1:0] y_hold;
    logic           s_hold, o_hold;
    int edges;

    rst = 1'b1; in_valid = 1'b0; a = '0; n = '0; out_ready = 1'b0;
    #2;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.y",         32'(y),         32'd0);
    check("reset.sticky",    32'(sticky),    32'd0);
    check("reset.ovf",       32'(ovf),       32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);

    run_op("d0", 15'h0B40, 3'd6);
    run_op("d1", 15'h0B41, 3'd6);
    run_op("d2", 15'h7FFF, 3'd7);
    run_op("n0a", 15'h00FF, 3'd0);
    run_op("n0b", 15'h01FF, 3'd0);

    // Backpressure: result must hold for 5 cycles with out_ready low.
    @(negedge clk);
    ra = 15'h5A5B; rn = 3'd3;
    in_valid = 1'b1; a = ra; n = rn; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    check("bp.latency", 32'(edges), 32'd4);
    check_result("bp", ra, rn);
    y_hold = y; s_hold = sticky; o_hold = ovf;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      a = DOW'($urandom); n = SW'($urandom);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.in_ready",  32'(in_ready),  32'd0);
      check("bp.y_hold",    32'(y),         32'(y_hold));
      check("bp.s_hold",    32'(sticky),    32'(s_hold));
      check("bp.o_hold",    32'(ovf),       32'(o_hold));
    end
    check_result("bp.final", ra, rn);
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_rel", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    check("bp.idle_valid", 32'(out_valid), 32'd0);
    check("bp.idle_ready", 32'(in_ready),  32'd1);

    // Back-to-back with in_valid held high, n=2: a result every 3 edges.
    foreach (q[i]) q[i] = DOW'($urandom);
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; n = 3'd2; a = q[0];
    for (int i = 0; i < 5; i++) begin
      edges = 0;
      do begin
        @(posedge clk); edges++; @(negedge clk);
        if (!out_valid) check("b2b.shift_ready", 32'(in_ready), 32'd0);
      end while (!out_valid && edges < 10);
      check("b2b.period", 32'(edges), 32'd3);
      check_result("b2b", q[i], 3'd2);
      check("b2b.in_ready", 32'(in_ready), 32'd1);
      if (i < 4) a = q[i+1];
      else       in_valid = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    check("b2b.end_valid", 32'(out_valid), 32'd0);

    // Reset mid-operation: asynchronous clear, no stale result afterwards.
    @(negedge clk);
    in_valid = 1'b1; a = 15'h7FFF; n = 3'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.y",         32'(y),         32'd0);
    check("rst.sticky",    32'(sticky),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst.no_stale", 32'(out_valid), 32'd0);
    end

    // Random operands against the model.
    for (int i = 0; i < 25; i++) begin
      ra = DOW'($urandom);
      rn = SW'($urandom_range(0, 7));
      run_op("rand", ra, rn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
